// File: rtl/cpu_sequencer.sv
// cpu_sequencer: FETCH/EXEC phase sequencer with run/halt/step control and halted-only loader RAM write port.
// Define SEQ_INSTRET_EN to build the retired-instruction counter; otherwise instret is tied to 0.
module cpu_sequencer #(
  parameter int HALT_DEST = 7,
  parameter int COUNT_W   = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               run,
  input  logic               step,
  input  logic               halt_req,
  input  logic [7:0]         ir,
  input  logic               ld_req,
  input  logic [7:0]         ld_addr,
  input  logic [7:0]         ld_data,
  output logic               ld_ack,
  output logic               ir_load,
  output logic               pc_inc,
  output logic               exec_en,
  output logic               mem_sel_loader,
  output logic               mem_we_loader,
  output logic               halted,
  output logic [1:0]         state,
  output logic [COUNT_W-1:0] instret
);
  typedef enum logic [1:0] {S_HALTED = 2'd0, S_FETCH = 2'd1, S_EXEC = 2'd2, S_LOAD = 2'd3} state_t;
  state_t r_state;
  logic   r_step;
  logic   w_halt_op, w_imm_src, w_unused;
  assign w_halt_op = ir[2:0] == 3'(HALT_DEST);
  assign w_imm_src = ir[5:3] == 3'd0 && ir[2:0] != 3'd1;
  // loader address/data are muxed into RAM outside this block
  assign w_unused  = &{1'b0, ir[7:6], ld_addr, ld_data};
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_HALTED;
      r_step  <= 1'b0;
    end else begin
      case (r_state)
        S_HALTED: begin
          if (ld_req) r_state <= S_LOAD;
          else if (step) begin
            r_state <= S_FETCH;
            r_step  <= 1'b1;
          end else if (run && !halt_req) begin
            r_state <= S_FETCH;
            r_step  <= 1'b0;
          end
        end
        S_FETCH: r_state <= S_EXEC;
        S_EXEC: begin
          if (w_halt_op || r_step || halt_req || !run) begin
            r_state <= S_HALTED;
            r_step  <= 1'b0;
          end else r_state <= S_FETCH;
        end
        default: r_state <= S_HALTED;
      endcase
    end
  end
`ifdef SEQ_INSTRET_EN
  logic [COUNT_W-1:0] r_instret;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_instret <= '0;
    else if (r_state == S_EXEC) r_instret <= r_instret + COUNT_W'(1);
  end
  assign instret = r_instret;
`else
  assign instret = '0;
`endif
  assign state          = r_state;
  assign halted         = r_state == S_HALTED;
  assign ir_load        = r_state == S_FETCH;
  assign pc_inc         = r_state == S_FETCH || (r_state == S_EXEC && w_imm_src);
  assign exec_en        = r_state == S_EXEC && !w_halt_op;
  assign ld_ack         = r_state == S_LOAD;
  assign mem_sel_loader = r_state == S_LOAD;
  assign mem_we_loader  = r_state == S_LOAD;
endmodule

// File: tb/tb_cpu_sequencer.sv
// tb_cpu_sequencer: directed and randomized checks of cpu_sequencer against a phase-level reference model.
module tb_cpu_sequencer;
  localparam int CW = 8;
  logic clk = 0, reset = 1, run = 0, step = 0, halt_req = 0, ld_req = 0;
  logic [7:0] ir = 0, ld_addr = 0, ld_data = 0;
  logic ld_ack, ir_load, pc_inc, exec_en, mem_sel_loader, mem_we_loader, halted;
  logic [1:0] state;
  logic [CW-1:0] instret;
  int errors = 0, checks = 0;
  int m_st = 0, m_cnt = 0;
  bit m_step = 0;

  cpu_sequencer #(.HALT_DEST(7), .COUNT_W(CW)) dut (
    .clk(clk), .reset(reset), .run(run), .step(step), .halt_req(halt_req), .ir(ir),
    .ld_req(ld_req), .ld_addr(ld_addr), .ld_data(ld_data), .ld_ack(ld_ack), .ir_load(ir_load),
    .pc_inc(pc_inc), .exec_en(exec_en), .mem_sel_loader(mem_sel_loader), .mem_we_loader(mem_we_loader),
    .halted(halted), .state(state), .instret(instret));

  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got=%0h expected=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic int exp_cnt(input int n);
`ifdef SEQ_INSTRET_EN
    return n % (1 << CW);
`else
    return 0;
`endif
  endfunction

  task automatic compare();
    bit is_exec;
    is_exec = m_st == 2;
    check("state", 32'(state), m_st);
    check("halted", 32'(halted), 32'(m_st == 0));
    check("ir_load", 32'(ir_load), 32'(m_st == 1));
    check("pc_inc", 32'(pc_inc), 32'(m_st == 1 || (is_exec && ir[5:3] == 0 && ir[2:0] != 1)));
    check("exec_en", 32'(exec_en), 32'(is_exec && ir[2:0] != 7));
    check("ld_ack", 32'(ld_ack), 32'(m_st == 3));
    check("mem_sel_loader", 32'(mem_sel_loader), 32'(m_st == 3));
    check("mem_we_loader", 32'(mem_we_loader), 32'(m_st == 3));
    check("instret", 32'(instret), exp_cnt(m_cnt));
  endtask

  task automatic advance();
    case (m_st)
      0: if (ld_req) m_st = 3;
         else if (step) begin m_st = 1; m_step = 1; end
         else if (run && !halt_req) begin m_st = 1; m_step = 0; end
      1: m_st = 2;
      2: begin
        m_cnt = (m_cnt + 1) % (1 << CW);
        if (ir[2:0] == 7 || m_step || halt_req || !run) begin m_st = 0; m_step = 0; end
        else m_st = 1;
      end
      default: m_st = 0;
    endcase
  endtask

  // One cycle: drive inputs after the falling edge, compare, optionally pulse async reset, then step the model.
  task automatic cyc(input bit r, input bit rn, input bit st, input bit hr, input bit lr, input logic [7:0] i);
    @(negedge clk);
    run = rn; step = st; halt_req = hr; ld_req = lr; ir = i;
    ld_addr = 8'($urandom); ld_data = 8'($urandom);
    #1 compare();
    if (r) begin
      #1 reset = 1;
      #1 check("rst_state", 32'(state), 0);
      check("rst_ld_ack", 32'(ld_ack), 0);
      check("rst_halted", 32'(halted), 1);
      reset = 0;
      m_st = 0; m_step = 0; m_cnt = 0;
      #1 compare();
    end
    advance();
  endtask

  initial begin
    #12 reset = 0;
    repeat (10) cyc(0, 0, 0, 0, 0, 8'h00);
    check("idle_state", 32'(state), 0);
    check("idle_instret", 32'(instret), 0);
    cyc(0, 0, 0, 0, 1, 8'h00);
    ld_addr = 8'h20; ld_data = 8'hA5;
    cyc(0, 0, 0, 0, 0, 8'h00);
    check("load_state", 32'(state), 3);
    check("load_ack", 32'(ld_ack), 1);
    cyc(0, 0, 0, 0, 0, 8'h00);
    check("load_done_ack", 32'(ld_ack), 0);
    cyc(0, 1, 0, 0, 1, 8'h00);
    cyc(0, 0, 0, 0, 0, 8'h00);
    check("load_prio_state", 32'(state), 3);
    cyc(0, 0, 0, 0, 0, 8'h00);
    cyc(0, 0, 1, 0, 0, 8'h02);
    cyc(0, 0, 0, 0, 0, 8'h02);
    check("step_fetch_irload", 32'(ir_load), 1);
    cyc(0, 0, 0, 0, 0, 8'h02);
    check("step_exec_en", 32'(exec_en), 1);
    check("step_exec_pcinc", 32'(pc_inc), 1);
    cyc(0, 0, 0, 0, 0, 8'h02);
    check("step_halted", 32'(state), 0);
    check("step_instret", 32'(instret), exp_cnt(1));
    cyc(0, 1, 0, 0, 0, 8'h19);
    cyc(0, 1, 0, 0, 0, 8'h19);
    cyc(0, 1, 0, 0, 0, 8'h19);
    check("run_exec_pcinc", 32'(pc_inc), 0);
    cyc(0, 1, 0, 1, 0, 8'h19);
    check("halt_req_fetch", 32'(state), 1);
    cyc(0, 1, 0, 1, 0, 8'h19);
    check("halt_req_exec", 32'(exec_en), 1);
    cyc(0, 0, 0, 0, 0, 8'h19);
    check("halt_req_halted", 32'(state), 0);
    cyc(0, 1, 0, 0, 0, 8'h07);
    cyc(0, 1, 0, 0, 0, 8'h07);
    cyc(0, 1, 0, 0, 0, 8'h07);
    check("halt_op_exec_en", 32'(exec_en), 0);
    cyc(0, 0, 0, 0, 0, 8'h07);
    check("halt_op_state", 32'(state), 0);
    check("halt_op_instret", 32'(instret), exp_cnt(4));
    cyc(0, 0, 0, 0, 1, 8'h00);
    cyc(1, 0, 0, 0, 0, 8'h00);
    cyc(0, 0, 0, 0, 0, 8'h00);
    check("post_rst_instret", 32'(instret), 0);
    cyc(0, 1, 0, 0, 0, 8'h19);
    for (int k = 0; k < (1 << CW); k++) begin
      cyc(0, 1, 0, 0, 0, 8'h19);
      cyc(0, k != (1 << CW) - 1, 0, 0, 0, 8'h19);
      if (k == (1 << CW) - 1) check("wrap_pre", 32'(instret), exp_cnt((1 << CW) - 1));
    end
    cyc(0, 0, 0, 0, 0, 8'h19);
    check("wrap_zero", 32'(instret), 0);
    for (int n = 0; n < 3000; n++)
      cyc($urandom_range(0, 299) == 0, $urandom_range(0, 3) != 0, $urandom_range(0, 9) == 0,
          $urandom_range(0, 7) == 0, $urandom_range(0, 9) == 0, 8'($urandom));
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/cpu_sequencer.md
Name: cpu_sequencer

Overview:
- Phase sequencer for the nic8 8-bit datapath. Steps each instruction through FETCH, then EXEC.
- Provides run / halt / single-step control.
- Shares the RAM write port between the CPU and an external program loader, which may use it only while halted.
- Sits between the front-panel/loader logic and the instruction decoder; qualifies when IR loads, when PC increments and when decoded strobes may fire.

Parameters:
- HALT_DEST, 7: dest field value (ir[2:0]) that encodes HALT. This dest code is otherwise unused by the decoder.
- COUNT_W, 16: width of the retired-instruction counter.

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- run  in  1  level; start free-running from HALTED.
- step  in  1  single-cycle pulse; execute exactly one instruction from HALTED.
- halt_req  in  1  level; stop at the next instruction boundary.
- ir  in  8  current instruction register contents {bit7, bit6, source[2:0], dest[2:0]}.
- ld_req  in  1  loader request; held until ld_ack.
- ld_addr  in  8  loader RAM address.
- ld_data  in  8  loader RAM data.
- ld_ack  out  1  one-cycle acknowledge; the write has been performed.
- ir_load  out  1  load IR from ROM[PC] this cycle.
- pc_inc  out  1  increment PC this cycle.
- exec_en  out  1  gates decoder load/store strobes; high only in EXEC.
- mem_sel_loader  out  1  RAM address/data muxed from the ld_* ports.
- mem_we_loader  out  1  RAM write strobe from the loader.
- halted  out  1  high in the HALTED state.
- state  out  2  encoding: HALTED=0, FETCH=1, EXEC=2, LOAD=3.
- instret  out  COUNT_W  retired-instruction count (see Optional Feature).

Behaviour:
- Reset (asynchronous):
  - State goes to HALTED.
  - All strobes are 0 and halted=1.
  - instret=0 and the internal step/free-run flags are cleared.
  - Reset asserted mid-instruction or mid-load abandons the operation immediately; no ld_ack is issued.
- HALTED:
  - ld_req=1 → LOAD. Loader has the highest priority: it wins over run and step arriving in the same cycle.
  - Otherwise step=1 → FETCH with single-step flag set.
  - Otherwise run=1 and halt_req=0 → FETCH with free-run flag set.
  - Otherwise remain in HALTED.
- FETCH (1 cycle):
  - ir_load=1 and pc_inc=1; exec_en=0.
  - Next state is always EXEC.
- EXEC (1 cycle):
  - exec_en=1.
  - pc_inc=1 only if source==0 (immediate operand consumed from ROM) and dest!=1 (not a PC load/jump).
  - The instruction retires at the end of EXEC and instret increments, wrapping from 2^COUNT_W-1 to 0.
  - If ir[2:0]==HALT_DEST: exec_en is forced 0 (no datapath strobe) and next state is HALTED. The instruction still counts as retired.
  - Otherwise, if single-step, halt_req=1, or run=0: next state is HALTED and both flags are cleared.
  - Otherwise next state is FETCH.
- LOAD (1 cycle):
  - mem_sel_loader=1, mem_we_loader=1, ld_ack=1.
  - Next state is HALTED. A held ld_req re-enters LOAD on the following cycle; the loader must drop ld_req after ld_ack.
- Loader requests while not HALTED are ignored (no ack) until the CPU halts.
- halt_req asserted during FETCH takes effect at the end of the following EXEC. An instruction is never split.
- step while running is ignored.
- All outputs decode from registered state only (Moore machine), except the EXEC pc_inc and exec_en qualifiers, which decode combinationally from ir.

Optional Feature:
- Macro: SEQ_INSTRET_EN.
- Defined: the COUNT_W-bit instret counter is implemented as described.
- Undefined: the counter is not built and instret is tied to 0; all other behaviour is identical.

Test Plan:
- Reset released with run=0 → state=0, halted=1, all strobes 0, instret=0; no change after 10 cycles.
- HALTED, ld_req=1, ld_addr=8'h20, ld_data=8'hA5 → next cycle state=3, mem_we_loader=1, ld_ack=1 for exactly 1 cycle, then state=0. Assert run and ld_req together → LOAD is taken first.
- step pulse with ir=8'h02 (load A from ROM immediate) → FETCH (ir_load=1, pc_inc=1), EXEC (exec_en=1, pc_inc=1), HALTED; instret=1.
- run=1 with ir=8'h19 (source=3, dest=1) → repeating FETCH/EXEC with pc_inc=0 in EXEC. Raise halt_req during FETCH → exactly one more EXEC, then HALTED.
- Free-run, ir=8'h07 (HALT) → EXEC has exec_en=0, then HALTED although run=1; instret incremented by 1.
- Assert reset during LOAD → immediate state=0, no ld_ack. Counter wrap: preload 16'hFFFF via 65535 steps (or force) → next retire gives instret=0.
